// File: rtl/ls_queue_param_if.sv
// Handshake/bus bundle between dispatcher/ROB/CDB/LSU and the load/store queue.
// The queue connects through the slave modport; the driving environment uses master.
interface ls_queue_param_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic              rdy;
  // Dispatcher enqueue
  logic              enq_valid;
  logic [OP_W-1:0]   enq_op;
  logic [ROB_W-1:0]  enq_q1;
  logic [ROB_W-1:0]  enq_q2;
  logic [DATA_W-1:0] enq_v1;
  logic [DATA_W-1:0] enq_v2;
  logic [DATA_W-1:0] enq_imm;
  logic [ROB_W-1:0]  enq_rob_id;
  // CDB snoop ports (0 = ALU, 1 = LSU)
  logic              cdb0_valid;
  logic [ROB_W-1:0]  cdb0_rob_id;
  logic [DATA_W-1:0] cdb0_data;
  logic              cdb1_valid;
  logic [ROB_W-1:0]  cdb1_rob_id;
  logic [DATA_W-1:0] cdb1_data;
  // ROB interaction
  logic              commit_valid;
  logic [ROB_W-1:0]  commit_rob_id;
  logic [ROB_W-1:0]  io_rob_id_in;
  logic [ROB_W-1:0]  io_rob_id_out;
  logic              flush;
  // LSU request
  logic              lsu_busy;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic [ROB_W-1:0]  issue_rob_id;
  // Status
  logic              full;
  logic [IDX_W:0]    count;

  modport slave (
    input  rdy, enq_valid, enq_op, enq_q1, enq_q2, enq_v1, enq_v2, enq_imm, enq_rob_id,
    input  cdb0_valid, cdb0_rob_id, cdb0_data, cdb1_valid, cdb1_rob_id, cdb1_data,
    input  commit_valid, commit_rob_id, io_rob_id_in, flush, lsu_busy,
    output io_rob_id_out, issue_valid, issue_op, issue_addr, issue_data, issue_rob_id,
    output full, count
  );

  modport master (
    output rdy, enq_valid, enq_op, enq_q1, enq_q2, enq_v1, enq_v2, enq_imm, enq_rob_id,
    output cdb0_valid, cdb0_rob_id, cdb0_data, cdb1_valid, cdb1_rob_id, cdb1_data,
    output commit_valid, commit_rob_id, io_rob_id_in, flush, lsu_busy,
    input  io_rob_id_out, issue_valid, issue_op, issue_addr, issue_data, issue_rob_id,
    input  full, count
  );
endinterface

// File: rtl/ls_queue_param.sv
// In-order load/store queue: circular FIFO between dispatcher and LSU.
// Two CDB snoop ports with same-cycle enqueue bypass; flush keeps the committed-store prefix.
// Optional statistics counters are enabled by defining LSQ_STATS_EN.
`ifndef OPENUM_LHU
`define OPENUM_LHU 4
`endif

module ls_queue_param #(
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       IDX_W       = 4,
  parameter int unsigned       ROB_W       = 4,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       OP_W        = 6,
  parameter int unsigned       FULL_MARGIN = 3,
  parameter logic [DATA_W-1:0] IO_ADDR     = 'h30000
) (
  input  logic                clk,
  input  logic                rst,
  ls_queue_param_if.slave     bus
`ifdef LSQ_STATS_EN
  ,
  output logic [31:0]         stat_loads,
  output logic [31:0]         stat_stores,
  output logic [31:0]         stat_stall
`endif
);

  // Entry storage
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  committed_q, committed_d;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [OP_W-1:0]   op_d  [DEPTH];
  logic [ROB_W-1:0]  q1_q  [DEPTH];
  logic [ROB_W-1:0]  q1_d  [DEPTH];
  logic [ROB_W-1:0]  q2_q  [DEPTH];
  logic [ROB_W-1:0]  q2_d  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v1_d  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  logic [DATA_W-1:0] v2_d  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [DATA_W-1:0] imm_d [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [ROB_W-1:0]  rob_d [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic              issue_valid_q, issue_valid_d;
  logic [OP_W-1:0]   issue_op_q, issue_op_d;
  logic [DATA_W-1:0] issue_addr_q, issue_addr_d;
  logic [DATA_W-1:0] issue_data_q, issue_data_d;
  logic [ROB_W-1:0]  issue_rob_id_q, issue_rob_id_d;

  logic [DATA_W-1:0] head_addr;
  logic              head_is_load;
  logic              head_ready;
  logic              do_issue;
  logic [DEPTH-1:0]  keep;
  logic [IDX_W:0]    prefix_len;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op <= OP_W'(`OPENUM_LHU);
  endfunction

  // Resolve one operand against both CDB ports; cdb0 has priority, tag 0 never matches.
  function automatic logic [ROB_W+DATA_W-1:0] snoop(
    input logic [ROB_W-1:0]  q,
    input logic [DATA_W-1:0] v,
    input logic              c0_v,
    input logic [ROB_W-1:0]  c0_id,
    input logic [DATA_W-1:0] c0_d,
    input logic              c1_v,
    input logic [ROB_W-1:0]  c1_id,
    input logic [DATA_W-1:0] c1_d
  );
    if (q != '0 && c0_v && q == c0_id) return {ROB_W'(0), c0_d};
    if (q != '0 && c1_v && q == c1_id) return {ROB_W'(0), c1_d};
    return {q, v};
  endfunction

  assign head_addr    = v1_q[head_q] + imm_q[head_q];
  assign head_is_load = is_load(op_q[head_q]);

  // Head issue decision: operands ready, LSU free, IO loads gated by ROB, stores by commit.
  always_comb begin
    head_ready = busy_q[head_q] && q1_q[head_q] == '0 && q2_q[head_q] == '0 && !bus.lsu_busy;
    if (head_is_load) begin
      head_ready = head_ready && (head_addr != IO_ADDR || bus.io_rob_id_in == rob_q[head_q]);
    end else begin
      head_ready = head_ready && committed_q[head_q];
    end
    // During flush only a committed store may still leave.
    do_issue = bus.rdy && head_ready && (!bus.flush || !head_is_load);
  end

  // Contiguous committed-store prefix starting at head, survives a flush.
  always_comb begin
    logic             run;
    logic [IDX_W-1:0] idx;
    run        = 1'b1;
    idx        = '0;
    keep       = '0;
    prefix_len = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + IDX_W'(i);
      if (run && (IDX_W+1)'(i) < count_q && busy_q[idx] && committed_q[idx] &&
          !is_load(op_q[idx])) begin
        keep[idx]  = 1'b1;
        prefix_len = prefix_len + (IDX_W+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next-state for entries, pointers, occupancy and the issue register.
  always_comb begin
    busy_d         = busy_q;
    committed_d    = committed_q;
    op_d           = op_q;
    q1_d           = q1_q;
    q2_d           = q2_q;
    v1_d           = v1_q;
    v2_d           = v2_q;
    imm_d          = imm_q;
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    issue_valid_d  = do_issue;
    issue_op_d     = issue_op_q;
    issue_addr_d   = issue_addr_q;
    issue_data_d   = issue_data_q;
    issue_rob_id_d = issue_rob_id_q;

    if (do_issue) begin
      issue_op_d     = op_q[head_q];
      issue_addr_d   = head_addr;
      issue_data_d   = head_is_load ? '0 : v2_q[head_q];
      issue_rob_id_d = rob_q[head_q];
    end

    if (bus.rdy) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i], bus.cdb0_valid, bus.cdb0_rob_id,
                                     bus.cdb0_data, bus.cdb1_valid, bus.cdb1_rob_id,
                                     bus.cdb1_data);
          {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i], bus.cdb0_valid, bus.cdb0_rob_id,
                                     bus.cdb0_data, bus.cdb1_valid, bus.cdb1_rob_id,
                                     bus.cdb1_data);
          if (bus.commit_valid && rob_q[i] == bus.commit_rob_id) committed_d[i] = 1'b1;
        end
      end
    end

    if (do_issue) begin
      busy_d[head_q]      = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + IDX_W'(1);
    end

    if (bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!keep[i]) begin
          busy_d[i]      = 1'b0;
          committed_d[i] = 1'b0;
        end
      end
      tail_d  = head_q + prefix_len[IDX_W-1:0];
      count_d = prefix_len - (IDX_W+1)'(do_issue);
    end else if (bus.rdy) begin
      if (bus.enq_valid) begin
        // Written after the issue clear so a slot freed this cycle can be reused.
        busy_d[tail_q]      = 1'b1;
        committed_d[tail_q] = 1'b0;
        op_d[tail_q]        = bus.enq_op;
        imm_d[tail_q]       = bus.enq_imm;
        rob_d[tail_q]       = bus.enq_rob_id;
        {q1_d[tail_q], v1_d[tail_q]} = snoop(bus.enq_q1, bus.enq_v1, bus.cdb0_valid,
                                             bus.cdb0_rob_id, bus.cdb0_data, bus.cdb1_valid,
                                             bus.cdb1_rob_id, bus.cdb1_data);
        {q2_d[tail_q], v2_d[tail_q]} = snoop(bus.enq_q2, bus.enq_v2, bus.cdb0_valid,
                                             bus.cdb0_rob_id, bus.cdb0_data, bus.cdb1_valid,
                                             bus.cdb1_rob_id, bus.cdb1_data);
        tail_d = tail_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(bus.enq_valid) - (IDX_W+1)'(do_issue);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= '0;
      committed_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        rob_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_op_q     <= '0;
      issue_addr_q   <= '0;
      issue_data_q   <= '0;
      issue_rob_id_q <= '0;
    end else begin
      busy_q         <= busy_d;
      committed_q    <= committed_d;
      op_q           <= op_d;
      q1_q           <= q1_d;
      q2_q           <= q2_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      imm_q          <= imm_d;
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      issue_valid_q  <= issue_valid_d;
      issue_op_q     <= issue_op_d;
      issue_addr_q   <= issue_addr_d;
      issue_data_q   <= issue_data_d;
      issue_rob_id_q <= issue_rob_id_d;
    end
  end

  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_op      = issue_op_q;
  assign bus.issue_addr    = issue_addr_q;
  assign bus.issue_data    = issue_data_q;
  assign bus.issue_rob_id  = issue_rob_id_q;
  assign bus.count         = count_q;
  assign bus.full          = count_q >= (IDX_W+1)'(DEPTH - FULL_MARGIN);
  assign bus.io_rob_id_out = (busy_q[head_q] && head_addr == IO_ADDR) ? rob_q[head_q] : '0;

`ifdef LSQ_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_stall_q;
  logic        head_stalled;

  assign head_stalled = bus.rdy && busy_q[head_q] && !do_issue;

  // Saturating issue/stall counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (do_issue && head_is_load && stat_loads_q != '1) stat_loads_q <= stat_loads_q + 32'd1;
      if (do_issue && !head_is_load && stat_stores_q != '1) begin
        stat_stores_q <= stat_stores_q + 32'd1;
      end
      if (head_stalled && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_ls_queue_param.sv
// Directed bench for ls_queue_param: hand-computed expectations from the behaviour description.
module tb_ls_queue_param;
  localparam logic [5:0] OpLw = 6'd2;
  localparam logic [5:0] OpSw = 6'd7;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;

  ls_queue_param_if #(.IDX_W(4), .ROB_W(4), .DATA_W(32), .OP_W(6)) bus ();

`ifdef LSQ_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_stall;
`endif

  ls_queue_param dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef LSQ_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_step(input logic [5:0] op, input logic [3:0] q1, input logic [31:0] v1,
                          input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [3:0] rob);
    bus.enq_valid  = 1'b1;
    bus.enq_op     = op;
    bus.enq_q1     = q1;
    bus.enq_v1     = v1;
    bus.enq_q2     = q2;
    bus.enq_v2     = v2;
    bus.enq_imm    = imm;
    bus.enq_rob_id = rob;
    step();
    bus.enq_valid  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst              = 1'b1;
    bus.rdy          = 1'b1;
    bus.enq_valid    = 1'b0;
    bus.enq_op       = '0;
    bus.enq_q1       = '0;
    bus.enq_q2       = '0;
    bus.enq_v1       = '0;
    bus.enq_v2       = '0;
    bus.enq_imm      = '0;
    bus.enq_rob_id   = '0;
    bus.cdb0_valid   = 1'b0;
    bus.cdb0_rob_id  = '0;
    bus.cdb0_data    = '0;
    bus.cdb1_valid   = 1'b0;
    bus.cdb1_rob_id  = '0;
    bus.cdb1_data    = '0;
    bus.commit_valid = 1'b0;
    bus.commit_rob_id = '0;
    bus.io_rob_id_in = '0;
    bus.flush        = 1'b0;
    bus.lsu_busy     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_full", 64'(bus.full), 64'd0);
    check_eq("rst_io_out", 64'(bus.io_rob_id_out), 64'd0);

    // Plain load issues the cycle after enqueue
    enq_step(OpLw, 4'd0, 32'h100, 4'd0, 32'd0, 32'd4, 4'd1);
    check_eq("ld_count1", 64'(bus.count), 64'd1);
    step();
    check_eq("ld_issue_valid", 64'(bus.issue_valid), 64'd1);
    check_eq("ld_addr", 64'(bus.issue_addr), 64'h104);
    check_eq("ld_data", 64'(bus.issue_data), 64'd0);
    check_eq("ld_count0", 64'(bus.count), 64'd0);
    step();
    check_eq("ld_one_pulse", 64'(bus.issue_valid), 64'd0);

    // Store waits for commit
    enq_step(OpSw, 4'd0, 32'h200, 4'd0, 32'hAB, 32'd0, 4'd2);
    for (int i = 0; i < 5; i++) begin
      check_eq("st_wait", 64'(bus.issue_valid), 64'd0);
      step();
    end
    check_eq("st_count", 64'(bus.count), 64'd1);
    bus.commit_valid  = 1'b1;
    bus.commit_rob_id = 4'd2;
    step();
    bus.commit_valid  = 1'b0;
    check_eq("st_commit_edge", 64'(bus.issue_valid), 64'd0);
    step();
    check_eq("st_issue_valid", 64'(bus.issue_valid), 64'd1);
    check_eq("st_addr", 64'(bus.issue_addr), 64'h200);
    check_eq("st_data", 64'(bus.issue_data), 64'hAB);
    check_eq("st_op", 64'(bus.issue_op), 64'(OpSw));
    check_eq("st_rob", 64'(bus.issue_rob_id), 64'd2);

    // Same-cycle CDB1 bypass on enqueue
    bus.cdb1_valid  = 1'b1;
    bus.cdb1_rob_id = 4'd5;
    bus.cdb1_data   = 32'h77;
    enq_step(OpSw, 4'd0, 32'h300, 4'd5, 32'd0, 32'd0, 4'd4);
    bus.cdb1_valid  = 1'b0;
    bus.commit_valid  = 1'b1;
    bus.commit_rob_id = 4'd4;
    step();
    bus.commit_valid  = 1'b0;
    step();
    check_eq("byp_issue_valid", 64'(bus.issue_valid), 64'd1);
    check_eq("byp_data", 64'(bus.issue_data), 64'h77);
    check_eq("byp_addr", 64'(bus.issue_addr), 64'h300);

    // IO load gated by ROB permission
    enq_step(OpLw, 4'd0, 32'h30000, 4'd0, 32'd0, 32'd0, 4'd3);
    check_eq("io_out", 64'(bus.io_rob_id_out), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("io_wait", 64'(bus.issue_valid), 64'd0);
    end
    bus.io_rob_id_in = 4'd3;
    step();
    bus.io_rob_id_in = 4'd0;
    check_eq("io_issue_valid", 64'(bus.issue_valid), 64'd1);
    check_eq("io_addr", 64'(bus.issue_addr), 64'h30000);
    check_eq("io_rob", 64'(bus.issue_rob_id), 64'd3);
    check_eq("io_out_empty", 64'(bus.io_rob_id_out), 64'd0);

    // Flush keeps the two committed stores at head, drops three pending loads
    bus.lsu_busy = 1'b1;
    enq_step(OpSw, 4'd0, 32'h400, 4'd0, 32'd1, 32'd0, 4'd6);
    bus.commit_valid  = 1'b1;
    bus.commit_rob_id = 4'd6;
    enq_step(OpSw, 4'd0, 32'h404, 4'd0, 32'd2, 32'd0, 4'd7);
    bus.commit_rob_id = 4'd7;
    enq_step(OpLw, 4'd15, 32'd0, 4'd0, 32'd0, 32'd0, 4'd8);
    bus.commit_valid  = 1'b0;
    enq_step(OpLw, 4'd15, 32'd0, 4'd0, 32'd0, 32'd0, 4'd9);
    enq_step(OpLw, 4'd15, 32'd0, 4'd0, 32'd0, 32'd0, 4'd10);
    check_eq("fl_count_pre", 64'(bus.count), 64'd5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_eq("fl_count_post", 64'(bus.count), 64'd2);
    check_eq("fl_no_issue", 64'(bus.issue_valid), 64'd0);
    // Next enqueue must land right after the kept stores
    enq_step(OpLw, 4'd0, 32'h500, 4'd0, 32'd0, 32'd0, 4'd11);
    check_eq("fl_count_enq", 64'(bus.count), 64'd3);
    bus.lsu_busy = 1'b0;
    step();
    check_eq("fl_st0_rob", 64'(bus.issue_rob_id), 64'd6);
    check_eq("fl_st0_data", 64'(bus.issue_data), 64'd1);
    step();
    check_eq("fl_st1_rob", 64'(bus.issue_rob_id), 64'd7);
    check_eq("fl_st1_addr", 64'(bus.issue_addr), 64'h404);
    step();
    check_eq("fl_ld_rob", 64'(bus.issue_rob_id), 64'd11);
    check_eq("fl_ld_addr", 64'(bus.issue_addr), 64'h500);
    check_eq("fl_count_end", 64'(bus.count), 64'd0);

    // Full threshold: 13 of 16 entries
    bus.lsu_busy = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      enq_step(OpLw, 4'd0, 32'(i * 4), 4'd0, 32'd0, 32'd0, 4'(i));
      if (i == 12) check_eq("full_at12", 64'(bus.full), 64'd0);
    end
    check_eq("full_at13", 64'(bus.full), 64'd1);
    check_eq("full_count", 64'(bus.count), 64'd13);
    bus.lsu_busy = 1'b0;
    repeat (13) step();
    check_eq("drain_rob", 64'(bus.issue_rob_id), 64'd13);
    check_eq("drain_count", 64'(bus.count), 64'd0);
    step();

    // 20 back-to-back enqueue/issue pairs wrap both pointers
    for (int i = 0; i < 20; i++) begin
      enq_step(OpLw, 4'd0, 32'(i * 16), 4'd0, 32'd0, 32'd0, 4'((i % 15) + 1));
      bus.enq_valid = 1'b0;
      check_eq("wrap_count", 64'(bus.count), 64'd1);
      if (i > 0) check_eq("wrap_addr", 64'(bus.issue_addr), 64'((i - 1) * 16));
      // Keep streaming: re-arm enqueue next iteration without an idle cycle
    end
    step();
    check_eq("wrap_last_addr", 64'(bus.issue_addr), 64'(19 * 16));
    check_eq("wrap_count_end", 64'(bus.count), 64'd0);

    // Asynchronous reset while an issue is presented
    enq_step(OpLw, 4'd0, 32'h10, 4'd0, 32'd0, 32'd0, 4'd1);
    step();
    check_eq("rst_mid_pre", 64'(bus.issue_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 64'(bus.issue_valid), 64'd0);
    check_eq("rst_mid_addr", 64'(bus.issue_addr), 64'd0);
    check_eq("rst_mid_rob", 64'(bus.issue_rob_id), 64'd0);
    check_eq("rst_mid_count", 64'(bus.count), 64'd0);
    #2 rst = 1'b0;
    step();
    check_eq("post_rst_valid", 64'(bus.issue_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
